// File: rtl/cof_mem_pkg.sv
// Shared constants, FSM encoding and credit helper for the coefficient SRAM reader.
package cof_mem_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 12;
    localparam int unsigned DEF_LEN_WIDTH  = 12;
    localparam int unsigned REP_WIDTH      = 4;
    localparam int unsigned FIFO_DEPTH     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    localparam logic CEN_ACTIVE = 1'b0;
    localparam logic CEN_IDLE   = 1'b1;
    localparam logic WEN_READ   = 1'b1;

    // A new read may issue only if every word already owed to the FIFO,
    // plus this one, still fits after the pop happening this cycle.
    function automatic logic has_credit(input logic [1:0] fifo_count,
                                        input logic       rd_landing,
                                        input logic       rd_on_bus,
                                        input logic       popping);
        logic [2:0] owed;
        owed = 3'(fifo_count) + 3'(rd_landing) + 3'(rd_on_bus) - 3'(popping);
        return owed < 3'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/cof_rd_fifo2.sv
// Two-entry first-word-fall-through buffer carrying {last, data} from registers.
module cof_rd_fifo2
    import cof_mem_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             valid_q, valid_d;
    logic             do_pop;

    assign do_pop = pop_i && valid_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case ({push_i, do_pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d  = push_data_i;
                    count_d = 2'd1;
                end else if (count_q == 2'd1) begin
                    tail_d  = push_data_i;
                    count_d = 2'd2;
                end
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Count is unchanged; the new word lands behind whatever survives the pop.
                if (count_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: ;
        endcase
        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/cof_mem_reader.sv
// Coefficient SRAM read sequencer: issues block reads and streams words out valid/ready.
// Optional multi-pass block repeat is enabled with macro COF_RD_REPEAT_EN.
module cof_mem_reader
    import cof_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
`ifdef COF_RD_REPEAT_EN
    input  logic [REP_WIDTH-1:0]  rep_count,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  mem_sel,
    output logic                  mem_cen,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    rd_state_e             state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  mem_sel_q, mem_sel_d;
    logic                  mem_cen_q, mem_cen_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  bus_last_q, bus_last_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [REP_WIDTH-1:0]  rep_q, rep_d;

    logic                  iss;
    logic [ADDR_WIDTH-1:0] iss_addr, iss_base;
    logic [LEN_WIDTH-1:0]  iss_rem, iss_len;
    logic [REP_WIDTH-1:0]  iss_rep;
    logic [REP_WIDTH-1:0]  rep_in;
    logic                  rd_on_bus;
    logic                  pop;
    logic                  drained;
    logic [1:0]            fifo_count;
    logic                  fifo_valid;
    logic [DATA_WIDTH:0]   fifo_data;

`ifdef COF_RD_REPEAT_EN
    assign rep_in = rep_count;
`else
    assign rep_in = '0;
`endif

    assign rd_on_bus = (mem_cen_q == CEN_ACTIVE);
    assign pop       = fifo_valid && out_ready;
    assign drained   = !rd_on_bus && !inflight_q &&
                       ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

    // Next-state, read issue and pass bookkeeping.
    always_comb begin
        state_d         = state_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        mem_sel_d       = mem_sel_q;
        mem_cen_d       = CEN_IDLE;
        mem_addr_d      = mem_addr_q;
        bus_last_d      = 1'b0;
        inflight_d      = rd_on_bus;
        inflight_last_d = bus_last_q;
        next_addr_d     = next_addr_q;
        base_d          = base_q;
        len_d           = len_q;
        rem_d           = rem_q;
        rep_d           = rep_q;

        iss      = 1'b0;
        iss_addr = next_addr_q;
        iss_base = base_q;
        iss_rem  = rem_q;
        iss_len  = len_q;
        iss_rep  = rep_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        iss       = 1'b1;
                        iss_addr  = base_addr;
                        iss_base  = base_addr;
                        iss_rem   = length;
                        iss_len   = length;
                        iss_rep   = rep_in;
                        busy_d    = 1'b1;
                        mem_sel_d = 1'b1;
                        base_d    = base_addr;
                        len_d     = length;
                        state_d   = ST_READ;
                    end
                end
            end
            ST_READ: begin
                iss = has_credit(fifo_count, inflight_q, rd_on_bus, pop);
            end
            ST_DRAIN: begin
                if (drained) begin
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    mem_sel_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (iss) begin
            mem_cen_d  = CEN_ACTIVE;
            mem_addr_d = iss_addr;
            if (iss_rem == LEN_WIDTH'(1)) begin
                if (iss_rep == '0) begin
                    bus_last_d = 1'b1;
                    rem_d      = '0;
                    rep_d      = '0;
                    state_d    = ST_DRAIN;
                end else begin
                    // Pass finished: reload the block with no bubble.
                    rep_d       = iss_rep - REP_WIDTH'(1);
                    rem_d       = iss_len;
                    next_addr_d = iss_base;
                end
            end else begin
                rem_d       = iss_rem - LEN_WIDTH'(1);
                next_addr_d = iss_addr + ADDR_WIDTH'(1);
                rep_d       = iss_rep;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            mem_sel_q       <= 1'b0;
            mem_cen_q       <= CEN_IDLE;
            mem_addr_q      <= '0;
            bus_last_q      <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            next_addr_q     <= '0;
            base_q          <= '0;
            len_q           <= '0;
            rem_q           <= '0;
            rep_q           <= '0;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            mem_sel_q       <= mem_sel_d;
            mem_cen_q       <= mem_cen_d;
            mem_addr_q      <= mem_addr_d;
            bus_last_q      <= bus_last_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            next_addr_q     <= next_addr_d;
            base_q          <= base_d;
            len_q           <= len_d;
            rem_q           <= rem_d;
            rep_q           <= rep_d;
        end
    end

    cof_rd_fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, mem_rdata}),
        .pop_i       (pop),
        .valid_o     (fifo_valid),
        .data_o      (fifo_data),
        .count_o     (fifo_count)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_sel   = mem_sel_q;
    assign mem_cen   = mem_cen_q;
    assign mem_wen   = WEN_READ;
    assign mem_addr  = mem_addr_q;
    assign out_valid = fifo_valid;
    assign out_data  = fifo_data[DATA_WIDTH-1:0];
    assign out_last  = fifo_data[DATA_WIDTH];

endmodule

// File: tb/tb_cof_mem_reader.sv
// Scoreboard bench for cof_mem_reader: SRAM model, expected read/word/done queues, monitor.
module tb_cof_mem_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic [11:0] length;
    logic [3:0]  rep_count;
    logic        busy, done, mem_sel, mem_cen, mem_wen;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_data;

    int vectors   = 0;
    int miscmp    = 0;
    int issued    = 0;
    int accepted  = 0;
    int done_cnt  = 0;
    int exp_done  = 0;
    int rdy_mode  = 0;
    logic [15:0] salt = 16'h0;

    logic [11:0] addr_q[$];
    logic [32:0] exp_q[$];

    bit          hold_pend = 1'b0;
    logic [32:0] hold_word;

    always #5 clk = ~clk;

    cof_mem_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
`ifdef COF_RD_REPEAT_EN
        .rep_count (rep_count),
`endif
        .busy      (busy),
        .done      (done),
        .mem_sel   (mem_sel),
        .mem_cen   (mem_cen),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return {salt, 4'hC, a};
    endfunction

    // SRAM: data valid only in the cycle after a cen=0 cycle, garbage otherwise.
    always @(posedge clk) begin
        if (mem_cen == 1'b0) mem_rdata <= mem_word(mem_addr);
        else                 mem_rdata <= $urandom;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_done"},      64'(done),      64'd0);
        chk({tag, "_mem_sel"},   64'(mem_sel),   64'd0);
        chk({tag, "_mem_cen"},   64'(mem_cen),   64'd1);
        chk({tag, "_mem_wen"},   64'(mem_wen),   64'd1);
        chk({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_last"},  64'(out_last),  64'd0);
        chk({tag, "_out_data"},  64'(out_data),  64'd0);
    endtask

    // Ready driver: 0 = always ready, 1 = toggle each cycle, 2 = random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares every read issue, every stream handoff and every done pulse.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_word", 64'({out_last, out_data}), 64'(hold_word));
                end
                hold_pend = out_valid && !out_ready;
                hold_word = {out_last, out_data};
                if (mem_cen == 1'b0) begin
                    if (addr_q.size() == 0) begin
                        chk("unexpected_read_addr", 64'(mem_addr), 64'hFFFF_FFFF);
                    end else begin
                        chk("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
                    end
                    chk("mem_sel_on_read", 64'(mem_sel), 64'd1);
                    chk("mem_wen_on_read", 64'(mem_wen), 64'd1);
                    issued++;
                    chk("credit_outstanding_le2", 64'((issued - accepted) <= 2), 64'd1);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 64'({out_last, out_data}), 64'h1_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", 64'(out_data), 64'(e[31:0]));
                        chk("out_last", 64'(out_last), 64'(e[32]));
                    end
                    accepted++;
                end
                if (done) begin
                    done_cnt++;
                    chk("done_expected", 64'(exp_done > 0), 64'd1);
                    if (exp_done > 0) exp_done--;
                    chk("done_after_last_word", 64'(exp_q.size()), 64'd0);
                    chk("done_busy_clear", 64'(busy), 64'd0);
                    chk("done_mem_sel_clear", 64'(mem_sel), 64'd0);
                end
            end
        end
    end

    task automatic run_xfer(input logic [11:0] base, input int len, input int rep,
                            input int mode, input bit lat_chk, input bit busy_poke);
        int pre;
        int passes;
        logic [11:0] a;
        rdy_mode = mode;
        salt     = 16'($urandom);
`ifdef COF_RD_REPEAT_EN
        passes = rep + 1;
`else
        passes = 1;
`endif
        if (len > 0) begin
            for (int p = 0; p < passes; p++) begin
                for (int i = 0; i < len; i++) begin
                    a = base + 12'(i);
                    addr_q.push_back(a);
                    exp_q.push_back({1'((p == passes - 1) && (i == len - 1)), mem_word(a)});
                end
            end
        end
        exp_done++;
        pre = done_cnt;
        @(posedge clk);
        #2;
        start     = 1'b1;
        base_addr = base;
        length    = 12'(len);
        rep_count = 4'(rep);
        @(posedge clk);
        #1;
        if (len == 0) begin
            chk("len0_done", 64'(done), 64'd1);
            chk("len0_cen", 64'(mem_cen), 64'd1);
            chk("len0_valid", 64'(out_valid), 64'd0);
        end else begin
            chk("start_busy", 64'(busy), 64'd1);
            chk("start_cen", 64'(mem_cen), 64'd0);
            chk("start_sel", 64'(mem_sel), 64'd1);
        end
        #1;
        start     = 1'b0;
        base_addr = 12'($urandom);
        length    = 12'($urandom);
        if (len == 0) begin
            @(posedge clk);
            #1 chk("len0_done_once", 64'(done), 64'd0);
        end
        if (lat_chk) begin
            @(posedge clk);
            #1 chk("latency_not_yet", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1 chk("latency_first_valid", 64'(out_valid), 64'd1);
        end
        if (busy_poke) begin
            @(posedge clk);
            #2;
            start     = 1'b1;
            base_addr = 12'h7A0;
            length    = 12'd5;
            rep_count = 4'd3;
            @(posedge clk);
            #2 start  = 1'b0;
        end
        for (int c = 0; c < 2000 && done_cnt == pre; c++) @(posedge clk);
        chk("done_timeout", 64'(done_cnt - pre), 64'd1);
    endtask

    initial begin
        int pre_acc;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        rep_count = '0;
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("rst");
        #1 rst = 1'b0;

        run_xfer(12'h010, 4, 0, 0, 1'b1, 1'b0);
        run_xfer(12'h020, 8, 0, 1, 1'b0, 1'b0);
        run_xfer(12'hFFE, 4, 0, 2, 1'b0, 1'b0);
        run_xfer(12'h055, 0, 0, 0, 1'b0, 1'b0);
        run_xfer(12'h040, 10, 0, 2, 1'b0, 1'b1);
        run_xfer(12'h080, 1, 0, 1, 1'b0, 1'b0);

        // Reset after two of six words delivered: no done, buffered words dropped.
        rdy_mode = 0;
        salt     = 16'($urandom);
        for (int i = 0; i < 6; i++) begin
            addr_q.push_back(12'h300 + 12'(i));
            exp_q.push_back({1'(i == 5), mem_word(12'h300 + 12'(i))});
        end
        pre_acc = accepted;
        @(posedge clk);
        #2;
        start     = 1'b1;
        base_addr = 12'h300;
        length    = 12'd6;
        @(posedge clk);
        #2 start  = 1'b0;
        for (int c = 0; c < 200 && accepted < pre_acc + 2; c++) @(negedge clk);
        chk("midrst_two_delivered", 64'(accepted >= pre_acc + 2), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        addr_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1 chk_reset_vals("midrst");
        #1;
        rst      = 1'b0;
        accepted = issued;
        run_xfer(12'h123, 2, 0, 0, 1'b0, 1'b0);

`ifdef COF_RD_REPEAT_EN
        run_xfer(12'h100, 3, 2, 0, 1'b0, 1'b0);
        run_xfer(12'hFFF, 2, 1, 1, 1'b0, 1'b0);
`endif

        for (int t = 0; t < 25; t++) begin
            logic [11:0] b;
            b = (t % 4 == 0) ? 12'(12'hFF8 + 12'($urandom_range(0, 7))) : 12'($urandom);
            run_xfer(b, $urandom_range(0, 12), $urandom_range(0, 3),
                     $urandom_range(0, 2), 1'b0, 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("end_words_left", 64'(exp_q.size()), 64'd0);
        chk("end_reads_left", 64'(addr_q.size()), 64'd0);
        chk("end_done_owed", 64'(exp_done), 64'd0);
        chk("end_idle", 64'(busy), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule
